// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: shares the register-file write port between
// pipeline writeback and the multiply/divide result path.
//
// Ports:
//   Clk, Rst               clock, synchronous active-high reset
//   WbRegWr/WbRW/WbBusW    pipeline writeback request (never stalled)
//   MdValid/MdReady        Md result handshake
//   MdRW/MdBusW            Md result destination and data
//   IssueValid/IssueReady  decode reserves IssueRW for a Md op
//   IssueRW                register being reserved
//   RA, RB / HazA, HazB    decode operand hazard lookup
//   StallPipe              head result starving, pipeline must bubble
//   WawErr                 pipeline wrote a still-pending register
//   RegWr/RW/BusW          registered register-file write port
module regfile_write_scheduler #(
  parameter int MAX_WAIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        WbRegWr,
  input  logic [4:0]  WbRW,
  input  logic [31:0] WbBusW,
  input  logic        MdValid,
  output logic        MdReady,
  input  logic [4:0]  MdRW,
  input  logic [31:0] MdBusW,
  input  logic        IssueValid,
  output logic        IssueReady,
  input  logic [4:0]  IssueRW,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  output logic        HazA,
  output logic        HazB,
  output logic        StallPipe,
  output logic        WawErr,
  output logic        RegWr,
  output logic [4:0]  RW,
  output logic [31:0] BusW
);

  localparam logic [8:0] MaxW = 9'(MAX_WAIT);

  // 2-entry FIFO, entry 0 is the head
  logic [4:0]  f_rw  [2];
  logic [31:0] f_dat [2];
  logic [1:0]  f_cnt;

  logic [31:0] pend_q;
  logic [7:0]  wait_q;
  logic        src_md_q;

  logic        wb_eff;
  logic        md_acc;
  logic        md_live;
  logic        fifo_ne;
  logic        sel_wb;
  logic        sel_fifo;
  logic        sel_byp;
  logic        pop;
  logic        push;
  logic        wr_idx;
  logic        iss_set;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pend_d;
  logic        wait_inc;
  logic [8:0]  wait_sum;
  logic [7:0]  wait_d;
  logic        stall_d;

  assign MdReady    = !Rst && (f_cnt < 2'd2);
  assign IssueReady = !Rst && !pend_q[IssueRW];
  assign HazA       = pend_q[RA] && (RA != 5'd0);
  assign HazB       = pend_q[RB] && (RB != 5'd0);

  assign wb_eff  = WbRegWr && (WbRW != 5'd0);
  assign md_acc  = MdValid && MdReady;
  // r0 results are consumed but otherwise dropped
  assign md_live = md_acc && (MdRW != 5'd0);
  assign fifo_ne = (f_cnt != 2'd0);

  // mutually exclusive slot winners, Wb first
  assign sel_wb   = wb_eff;
  assign sel_fifo = !wb_eff && fifo_ne;
  assign sel_byp  = !wb_eff && !fifo_ne && md_live;

  assign pop  = sel_fifo;
  assign push = md_live && !sel_byp;
  // after an optional pop, the new entry lands behind what remains
  assign wr_idx = (f_cnt == 2'd1) && !pop;

  assign iss_set  = IssueValid && IssueReady
                  && (IssueRW != 5'd0);
  assign set_mask = 32'(iss_set) << IssueRW;
  // the edge that commits an Md write also releases its reservation
  assign clr_mask = 32'(RegWr && src_md_q) << RW;
  assign pend_d   = (pend_q & ~clr_mask) | set_mask;

  assign wait_inc = fifo_ne && !pop;
  assign wait_sum = {1'b0, wait_q} + 9'd1;
  assign stall_d  = wait_inc && (wait_sum >= MaxW);

  always_comb begin
    wait_d = 8'd0;
    if (wait_inc) begin
      // saturate so a very long wait cannot drop the stall
      if (wait_q == 8'hFF) wait_d = 8'hFF;
      else                 wait_d = wait_sum[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      f_cnt <= 2'd0;
    end else begin
      if (pop) begin
        f_rw[0]  <= f_rw[1];
        f_dat[0] <= f_dat[1];
      end
      if (push) begin
        f_rw[wr_idx]  <= MdRW;
        f_dat[wr_idx] <= MdBusW;
      end
      f_cnt <= f_cnt + {1'b0, push}
                     - {1'b0, pop};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWr    <= 1'b0;
      RW       <= 5'd0;
      BusW     <= 32'd0;
      src_md_q <= 1'b0;
    end else begin
      unique case (1'b1)
        sel_wb: begin
          RegWr    <= 1'b1;
          RW       <= WbRW;
          BusW     <= WbBusW;
          src_md_q <= 1'b0;
        end
        sel_fifo: begin
          RegWr    <= 1'b1;
          RW       <= f_rw[0];
          BusW     <= f_dat[0];
          src_md_q <= 1'b1;
        end
        sel_byp: begin
          RegWr    <= 1'b1;
          RW       <= MdRW;
          BusW     <= MdBusW;
          src_md_q <= 1'b1;
        end
        default: begin
          RegWr    <= 1'b0;
          src_md_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend_q    <= 32'd0;
      wait_q    <= 8'd0;
      StallPipe <= 1'b0;
      WawErr    <= 1'b0;
    end else begin
      pend_q    <= {pend_d[31:1], 1'b0};
      wait_q    <= wait_d;
      StallPipe <= stall_d;
      WawErr    <= wb_eff && pend_q[WbRW];
    end
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the 32x32 register file between the in-order pipeline writeback and a long-latency multiply/divide result path. It also keeps a per-register pending scoreboard so decode can stall on operands still owed by that unit. It sits between the writeback stage and the register file write inputs (RegWr, RW, BusW). It drives those inputs from a registered output stage and buffers deferred results in a 2-entry FIFO.

## Interface
- MAX_WAIT, 8: cycles a buffered Md result may wait at the FIFO head before StallPipe is raised (valid range 1..255).
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- WbRegWr  in  1  pipeline writeback request; never back-pressured.
- WbRW  in  5  pipeline destination register.
- WbBusW  in  32  pipeline write data.
- MdValid  in  1  Md result valid.
- MdReady  out  1  Md result accepted this cycle; = !Rst && fifo_count < 2.
- MdRW  in  5  Md destination register.
- MdBusW  in  32  Md result data.
- IssueValid  in  1  decode issues a Md op reserving IssueRW.
- IssueReady  out  1  = !Rst && !Pending[IssueRW].
- IssueRW  in  5  register reserved by the issued Md op.
- RA, RB  in  5 each  decode read addresses.
- HazA, HazB  out  1 each  combinational; = Pending[RA] && RA!=0, and likewise for RB.
- StallPipe  out  1  registered; request for a pipeline bubble.
- WawErr  out  1  registered one-cycle pulse; pipeline wrote a pending register.
- RegWr, RW, BusW  out  1/5/32  registered register-file write port.

## Operation
- Wb write is effective when WbRegWr && WbRW != 0. Otherwise the write slot is free.
- Md accepted = MdValid && MdReady. An accepted Md with MdRW == 0 is consumed and discarded. It is not pushed, not written, and has no scoreboard effect.
- Slot selection per cycle, in priority order:
  1. Effective Wb: load the output register with the Wb request and set src=WB.
  2. FIFO non-empty: load the FIFO head, pop it, set src=MD.
  3. Accepted Md with the FIFO empty: bypass it straight into the output register, src=MD.
  4. Otherwise: RegWr <= 0.
- An accepted Md not taking the slot is pushed. Push and pop in the same cycle are both legal. The FIFO count stays in 0..2, and MdReady does not look ahead to a same-cycle pop.
- Order: Md results are written in acceptance order. Wb may overtake buffered Md results.
- Scoreboard Pending[31:0]:
  - Set Pending[IssueRW] on IssueValid && IssueReady && IssueRW != 0.
  - Clear Pending[RW] on the edge where RegWr == 1 && src == MD, i.e. the edge on which the register file commits the data.
  - Set and clear of different registers on the same edge both take effect.
  - The same register cannot be set and cleared on the same edge, because IssueReady is low while the register is pending.
  - Pending[0] is always 0.
- WawErr <= 1 for one cycle when an effective Wb targets a register with Pending set. No other effect; the Wb write still proceeds.
- Starvation control:
  - wait_cnt increments each cycle the FIFO is non-empty and its head is not popped.
  - wait_cnt resets to 0 on a pop or when the FIFO is empty.
  - StallPipe <= (wait_cnt + 1 >= MAX_WAIT) while the head still waits. It clears on the edge the head is popped.
  - The block itself still gives Wb priority; the pipeline must bubble.

## Timing
- Reset (Rst high at posedge):
  - RegWr=0, RW=0, BusW=0, StallPipe=0, WawErr=0.
  - Pending cleared, FIFO emptied, wait_cnt=0.
  - MdReady=0 and IssueReady=0 while Rst is high.
- Reset mid-operation discards buffered Md results and all reservations. Nothing already in the output register is written after the reset edge.
- Latency:
  - Request to RegWr/RW/BusW valid: 1 cycle.
  - Request to data readable on the register file read bus: 2 edges.
- HazA/HazB:
  - Assert in the cycle after the issue edge.
  - Deassert in the cycle after the commit edge, when the register file already holds the data.
- Back-to-back Wb every cycle with the FIFO full: MdReady stays low; no Md result is lost.

## Test plan
- Reset, then Md {MdRW=5, MdBusW=0xDEADBEEF} alone:
  - Next cycle RegWr=1, RW=5, BusW=0xDEADBEEF.
  - FIFO count stays 0.
- Same cycle Wb {WbRW=3, WbBusW=0x11} and Md {MdRW=7, MdBusW=0x22}:
  - Cycle+1 writes r3=0x11.
  - Cycle+2 writes r7=0x22.
- Issue r9:
  - HazA=1 with RA=9.
  - Md r9 = 0x55 accepted at edge N; RegWr=1, RW=9 after edge N.
  - HazA=0 after edge N+1; IssueReady for r9 high after edge N+1.
- Continuous Wb, MAX_WAIT=4, three Md offered:
  - Two accepted, then MdReady=0.
  - StallPipe=1 after the 4th waiting cycle.
  - Dropping WbRegWr for one cycle drains the head, clears StallPipe, and raises MdReady.
- Pending r4, then Wb to r4:
  - WawErr pulses for exactly one cycle.
  - r4 is written with the Wb data.
- Md with MdRW=0, or Wb with WbRW=0, and Rst asserted while the FIFO holds 2 entries:
  - RegWr never rises for r0.
  - After reset: RegWr=0, Pending=0, MdReady=1.
